// File: rtl/nn_fixed_pkg.sv
// Fixed-point helpers shared by the forward neuron, neuron_delta and the weight updater.
// Holds state encoding, default fraction widths, clog2 and signed saturation.
package nn_fixed_pkg;

  localparam int DEFAULT_DELTA_FRACTION  = 8;
  localparam int DEFAULT_WEIGHT_FRACTION = 8;
  localparam int DEFAULT_DERIV_FRACTION  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Clamp a signed value to the range of a signed number 'width' bits wide (width <= 63).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/sat_shift.sv
// Arithmetic (floor) right shift followed by saturation to a narrower signed width.
// Purely combinational; IN_W must not exceed 64.
module sat_shift
  import nn_fixed_pkg::*;
#(
  parameter int IN_W  = 40,
  parameter int SHIFT = 8,
  parameter int OUT_W = 18
) (
  input  logic signed [IN_W-1:0]  i_data,
  output logic signed [OUT_W-1:0] o_data
);

  logic signed [IN_W-1:0] w_shifted;
  logic signed [63:0]     w_wide;

  assign w_shifted = i_data >>> SHIFT;
  assign w_wide    = 64'(w_shifted);
  assign o_data    = OUT_W'(saturate(w_wide, OUT_W));

endmodule

// File: rtl/neuron_delta.sv
// Backward-pass delta for one hidden neuron: serial sum of next-layer delta*weight,
// scaled by the local activation derivative and saturated to OUTPUT_SIZE.
module neuron_delta
  import nn_fixed_pkg::*;
#(
  parameter int NUM_OUTPUTS     = 5,
  parameter int DELTA_SIZE      = 18,
  parameter int WEIGHT_SIZE     = 17,
  parameter int DERIV_SIZE      = 9,
  parameter int OUTPUT_SIZE     = 18,
  parameter int DELTA_FRACTION  = DEFAULT_DELTA_FRACTION,
  parameter int WEIGHT_FRACTION = DEFAULT_WEIGHT_FRACTION,
  parameter int DERIV_FRACTION  = DEFAULT_DERIV_FRACTION
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NUM_OUTPUTS*DELTA_SIZE-1:0]  deltas,
  input  logic [NUM_OUTPUTS*WEIGHT_SIZE-1:0] weights,
  input  logic [DERIV_SIZE-1:0]              derivative,
  output logic                               busy,
  output logic [OUTPUT_SIZE-1:0]             out_delta,
  output logic                               out_valid
);

  localparam int SUM_SIZE  = DELTA_SIZE + WEIGHT_SIZE + clog2(NUM_OUTPUTS);
  localparam int TERM_SIZE = DELTA_SIZE + WEIGHT_SIZE;
  localparam int T_SIZE    = SUM_SIZE - WEIGHT_FRACTION;
  localparam int P_SIZE    = T_SIZE + DERIV_SIZE + 1;
  localparam int CNT_W     = (clog2(NUM_OUTPUTS) > 0) ? clog2(NUM_OUTPUTS) : 1;
  // After dropping the weight fraction, p carries delta+deriv fraction bits;
  // the output keeps only the delta fraction.
  localparam int P_FRACTION = DELTA_FRACTION + DERIV_FRACTION;
  localparam int R_SHIFT    = P_FRACTION - DELTA_FRACTION;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OUTPUTS - 1);

  logic signed [DELTA_SIZE-1:0]  w_delta  [NUM_OUTPUTS];
  logic signed [WEIGHT_SIZE-1:0] w_weight [NUM_OUTPUTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_unpack
      assign w_delta[gi]  = deltas[DELTA_SIZE*gi +: DELTA_SIZE];
      assign w_weight[gi] = weights[WEIGHT_SIZE*gi +: WEIGHT_SIZE];
    end
  endgenerate

  state_t                      r_state;
  logic signed [SUM_SIZE-1:0]  r_sum;
  logic [CNT_W-1:0]            r_counter;
  logic [DERIV_SIZE-1:0]       r_deriv;
  logic [OUTPUT_SIZE-1:0]      r_out_delta;
  logic                        r_busy;
  logic                        r_out_valid;

  logic signed [TERM_SIZE-1:0]   w_term;
  logic signed [T_SIZE-1:0]      w_t;
  logic signed [P_SIZE-1:0]      w_p;
  logic signed [OUTPUT_SIZE-1:0] w_sat;

  assign w_term = w_delta[r_counter] * w_weight[r_counter];
  assign w_t    = T_SIZE'(r_sum >>> WEIGHT_FRACTION);
  assign w_p    = P_SIZE'(w_t) * P_SIZE'($signed({1'b0, r_deriv}));

  sat_shift #(
    .IN_W  (P_SIZE),
    .SHIFT (R_SHIFT),
    .OUT_W (OUTPUT_SIZE)
  ) u_sat_shift (
    .i_data (w_p),
    .o_data (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sum       <= '0;
      r_counter   <= '0;
      r_deriv     <= '0;
      r_out_delta <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sum       <= '0;
            r_counter   <= '0;
            r_out_valid <= 1'b0;
            r_deriv     <= derivative;
            r_busy      <= 1'b1;
            r_state     <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_sum <= r_sum + SUM_SIZE'(w_term);
          if (r_counter == LAST_IDX) begin
            r_state <= ST_SCALE;
          end else begin
            r_counter <= r_counter + 1'b1;
          end
        end
        ST_SCALE: begin
          r_out_delta <= w_sat;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_delta = r_out_delta;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_neuron_delta.sv
// Self-checking bench for neuron_delta: directed vector table, control-corner sequences
// and randomized operands checked against an arithmetic reference model.
module tb_neuron_delta;

  localparam int N  = 5;
  localparam int DS = 18;
  localparam int WS = 17;
  localparam int RS = 9;
  localparam int OS = 18;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [N*DS-1:0]    deltas;
  logic [N*WS-1:0]    weights;
  logic [RS-1:0]      derivative;
  logic               busy;
  logic [OS-1:0]      out_delta;
  logic               out_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  neuron_delta dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .deltas     (deltas),
    .weights    (weights),
    .derivative (derivative),
    .busy       (busy),
    .out_delta  (out_delta),
    .out_valid  (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [N*DS-1:0] d;
    logic [N*WS-1:0] w;
    logic [RS-1:0]   der;
    longint          expect_out;
  } vec_t;

  task automatic check(input string name, input longint actual, input longint required);
    n_cmp++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  function automatic logic [N*DS-1:0] pack_d(input longint first, input longint rest);
    logic [N*DS-1:0] v;
    for (int i = 0; i < N; i++) v[DS*i +: DS] = DS'((i == 0) ? first : rest);
    return v;
  endfunction

  function automatic logic [N*WS-1:0] pack_w(input longint first, input longint rest);
    logic [N*WS-1:0] v;
    for (int i = 0; i < N; i++) v[WS*i +: WS] = WS'((i == 0) ? first : rest);
    return v;
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: real-valued dot product, two floor-divisions by 256, clamp to 18-bit signed.
  function automatic longint model(input logic [N*DS-1:0] d, input logic [N*WS-1:0] w,
                                   input logic [RS-1:0] der);
    longint s;
    longint r;
    logic signed [DS-1:0] a;
    logic signed [WS-1:0] b;
    s = 0;
    for (int i = 0; i < N; i++) begin
      a = d[DS*i +: DS];
      b = w[WS*i +: WS];
      s = s + longint'(a) * longint'(b);
    end
    r = floor_div(floor_div(s, 256) * longint'(der), 256);
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return r;
  endfunction

  function automatic longint sval(input logic [OS-1:0] v);
    logic signed [OS-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  // Issue start at edge k, optionally pulse start again at k+2 or hold it; return edges to valid.
  task automatic run(input bit pulse_again, input bit hold, output int lat, output bit busy_ok);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    busy_ok = busy && !out_valid;
    if (!hold) start = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (pulse_again && lat == 1) start = 1'b1;
      if (pulse_again && lat == 2) start = 1'b0;
      if (!out_valid && !busy) busy_ok = 1'b0;
    end
    if (out_valid && busy) busy_ok = 1'b0;
  endtask

  vec_t vecs[6];
  int   lat;
  bit   bok;
  string tag;

  initial begin
    vecs[0] = '{"basic",      pack_d(256, 256),        pack_w(256, 256),     9'd64,  320};
    vecs[1] = '{"neg_sparse", pack_d(-256, 0),         pack_w(512, 0),       9'd128, -256};
    vecs[2] = '{"floor_neg",  pack_d(-1, 0),           pack_w(1, 0),         9'd255, -1};
    vecs[3] = '{"floor_pos",  pack_d(1, 0),            pack_w(1, 0),         9'd255, 0};
    vecs[4] = '{"sat_pos",    pack_d(131071, 131071),  pack_w(65535, 65535), 9'd255, 131071};
    vecs[5] = '{"sat_neg",    pack_d(-131072, -131072), pack_w(65535, 65535), 9'd255, -131072};

    rst_n = 1'b0;
    start = 1'b0;
    deltas = '0;
    weights = '0;
    derivative = '0;
    #13;
    check("reset_busy", busy, 0);
    check("reset_valid", out_valid, 0);
    check("reset_out", sval(out_delta), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      deltas = vecs[i].d;
      weights = vecs[i].w;
      derivative = vecs[i].der;
      run(1'b0, 1'b0, lat, bok);
      check({vecs[i].name, "_latency"}, lat, 6);
      check({vecs[i].name, "_busy"}, bok, 1);
      check({vecs[i].name, "_out"}, sval(out_delta), vecs[i].expect_out);
      $display("vector %s: out_delta=%0d latency=%0d", vecs[i].name, sval(out_delta), lat);
    end

    // Second start during ACCUM must not disturb result or timing.
    deltas = vecs[0].d;
    weights = vecs[0].w;
    derivative = vecs[0].der;
    run(1'b1, 1'b0, lat, bok);
    check("restart_ignored_latency", lat, 6);
    check("restart_ignored_busy", bok, 1);
    check("restart_ignored_out", sval(out_delta), 320);
    $display("restart-during-accum: out_delta=%0d latency=%0d", sval(out_delta), lat);

    // Sticky valid over idle cycles; derivative change while idle must not matter.
    derivative = 9'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("sticky_valid", out_valid, 1);
      check("sticky_out", sval(out_delta), 320);
    end
    $display("sticky: out_valid=%0d out_delta=%0d after 10 idle cycles", out_valid, sval(out_delta));

    // Next accepted start drops out_valid on its edge; hold start to test back-to-back.
    derivative = vecs[0].der;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("start_clears_valid", out_valid, 0);
    check("start_sets_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_first_latency", lat, 6);
    check("b2b_first_out", sval(out_delta), 320);
    @(posedge clk);
    #1;
    check("b2b_second_accepted", out_valid, 0);
    check("b2b_second_busy", busy, 1);
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_second_latency", lat, 6);
    check("b2b_second_out", sval(out_delta), 320);
    $display("back-to-back: out_delta=%0d second latency=%0d", sval(out_delta), lat);

    // Asynchronous reset mid-computation, then a clean run.
    deltas = vecs[1].d;
    weights = vecs[1].w;
    derivative = vecs[1].der;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_valid", out_valid, 0);
    check("midreset_out", sval(out_delta), 0);
    $display("mid-run reset: busy=%0d out_valid=%0d out_delta=%0d", busy, out_valid, sval(out_delta));
    #4;
    rst_n = 1'b1;
    run(1'b0, 1'b0, lat, bok);
    check("postreset_latency", lat, 6);
    check("postreset_out", sval(out_delta), -256);
    $display("post-reset: out_delta=%0d latency=%0d", sval(out_delta), lat);

    // Randomized operands; narrow magnitudes on some trials to avoid constant saturation.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (t % 3 == 0) begin
          deltas[DS*i +: DS]  = DS'($urandom);
          weights[WS*i +: WS] = WS'($urandom);
        end else begin
          deltas[DS*i +: DS]  = DS'(longint'($urandom_range(0, 2047)) - 1024);
          weights[WS*i +: WS] = WS'(longint'($urandom_range(0, 1023)) - 512);
        end
      end
      derivative = RS'($urandom);
      run(1'b0, 1'b0, lat, bok);
      $sformat(tag, "random%0d", t);
      check({tag, "_latency"}, lat, 6);
      check({tag, "_out"}, sval(out_delta), model(deltas, weights, derivative));
      $display("%s: der=%0d out_delta=%0d model=%0d", tag, derivative, sval(out_delta),
               model(deltas, weights, derivative));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_delta.md
# neuron_delta

Backward-pass counterpart of the forward neuron. It serially accumulates the next layer's error terms weighted by their connection weights, scales the result by the local activation derivative, and emits a saturated signed fixed-point delta. One instance per hidden neuron feeds the weight-update logic and the previous layer's `neuron_delta` instances.

## Interface

Parameters:

- `NUM_OUTPUTS`, 5, number of next-layer neurons this neuron drives.
- `DELTA_SIZE`, 18, width of incoming next-layer deltas (signed).
- `WEIGHT_SIZE`, 17, width of connection weights (signed).
- `DERIV_SIZE`, 9, width of activation derivative (unsigned).
- `OUTPUT_SIZE`, 18, width of produced delta (signed).
- `DELTA_FRACTION`, 8, fraction bits of incoming and outgoing deltas.
- `WEIGHT_FRACTION`, 8, fraction bits of weights.
- `DERIV_FRACTION`, 8, fraction bits of derivative.

Ports:

- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `rst_n` input, 1 bit: reset. Asynchronous, active-low.
- `start` input, 1 bit: begin a computation; sampled only in IDLE.
- `deltas` input, `NUM_OUTPUTS*DELTA_SIZE` bits: packed deltas; element i is at `[DELTA_SIZE*i +: DELTA_SIZE]`.
- `weights` input, `NUM_OUTPUTS*WEIGHT_SIZE` bits: packed weights, same packing as `deltas`.
- `derivative` input, `DERIV_SIZE` bits: unsigned f'(z) of this neuron.
- `busy` output, 1 bit: high in ACCUM and SCALE.
- `out_delta` output, `OUTPUT_SIZE` bits: signed result delta, registered.
- `out_valid` output, 1 bit: `out_delta` holds a completed result.

## Operation

- States: IDLE, ACCUM, SCALE.
- **IDLE, `start`=1:**
  - clear `sum`, `counter` and `out_valid`;
  - capture `derivative` into an internal register;
  - go to ACCUM.
- **IDLE, `start`=0:** hold all state.
- **ACCUM:**
  - each cycle, `sum <= sum + deltas[counter]*weights[counter]` (signed×signed);
  - `counter` increments;
  - when `counter == NUM_OUTPUTS-1`, the final term is added and the state goes to SCALE.
- **SCALE:** in one cycle:
  - `t = sum >>> WEIGHT_FRACTION`;
  - `p = t * {0, deriv_reg}` (derivative zero-extended, signed multiply);
  - `r = p >>> DERIV_FRACTION`;
  - `out_delta <=` `r` saturated to signed `OUTPUT_SIZE`;
  - `out_valid <= 1`;
  - go to IDLE.
- **Widths:**
  - `SUM_SIZE = DELTA_SIZE + WEIGHT_SIZE + clog2(NUM_OUTPUTS)`;
  - `p` width is `SUM_SIZE - WEIGHT_FRACTION + DERIV_SIZE + 1`.
  - No intermediate overflow is permitted.
- **Rounding:** all right shifts are arithmetic, i.e. floor toward −∞.
- **Saturation bounds:** +2^(OUTPUT_SIZE-1)−1 and −2^(OUTPUT_SIZE-1).
- **Input stability:** `deltas` and `weights` must be stable from the `start` edge until `out_valid` rises. `derivative` need only be valid at the `start` edge.
- **`start` while not IDLE:** ignored, with no effect on the result or timing.
- **`out_valid`:** sticky. It stays high with `out_delta` held until the next accepted `start`, which drops it on that edge.
- **Reset:** on `rst_n` low, immediately, including mid-computation:
  - state goes to IDLE;
  - `sum`, `counter`, `deriv_reg`, `out_delta`, `busy` and `out_valid` go to 0.
- **After reset:** the first `start` following release behaves normally.

## Timing

- Reset values: `busy`=0, `out_valid`=0, `out_delta`=0.
- `start` sampled high in IDLE at edge k:
  - `busy` is high from k to k+NUM_OUTPUTS+1;
  - `out_valid`=1 and `out_delta` is valid from edge k+NUM_OUTPUTS+1;
  - latency is NUM_OUTPUTS+1 cycles.
- `busy` drops on the same edge that `out_valid` rises.
- Back-to-back: `start` held or reasserted in the first IDLE cycle after completion is accepted. Throughput is one result per NUM_OUTPUTS+2 cycles.
- The ACCUM multiply is combinational into the accumulator. No pipelining is required at default parameters.

## Structure

- Shared package `nn_fixed_pkg`, containing:
  - `clog2` function;
  - state encoding constants (IDLE/ACCUM/SCALE);
  - default fraction constants;
  - a saturate-to-width function usable by the forward neuron and the weight updater.
- One sub-module: `sat_shift`, a parameterised arithmetic right shift followed by signed saturation to a target width. It is instantiated once for the SCALE output.
- Unpacking of `deltas` and `weights` uses a generate loop into local wire arrays.

## Test plan

Defaults throughout; 1.0 = 256 for all operands.

- **Basic:** all deltas=256, all weights=256, derivative=64, start pulse at edge k.
  - `busy` is high from k to k+6.
  - `out_valid` rises at k+6 with `out_delta`=320 (1.25).
- **Negative, sparse:** delta[0]=−256, weight[0]=512, others 0, derivative=128 → `out_delta`=−256.
- **Floor rounding:**
  - delta[0]=−1, weight[0]=1, others 0, derivative=255 → `out_delta`=−1.
  - Same with delta[0]=+1 → `out_delta`=0.
- **Saturation:**
  - all deltas=131071, weights=65535, derivative=255 → `out_delta`=131071.
  - deltas=−131072, weights=65535 → `out_delta`=−131072.
- **Control:**
  - `start` pulsed again at k+2 during ACCUM → ignored; result and timing identical to the basic case.
  - `rst_n` low at k+3 → all outputs 0 immediately.
  - After release, a new start gives the correct result at latency 6.
- **Sticky valid:**
  - `out_valid` stays high with `out_delta` unchanged for 10 idle cycles.
  - The next accepted `start` clears `out_valid` on that edge.
